// File: rtl/fp32_pkg.sv
// Shared FP32 constants, accumulator state encoding and a leading-zero helper.
package fp32_pkg;

  localparam logic [31:0] FP32_ZERO = 32'h0;
  localparam int          EXP_W     = 8;
  localparam int          FRAC_W    = 23;
  localparam int          BIAS      = 127;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Leading zeros of a 24-bit mantissa; the highest set bit wins.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fpadd_unpipe.sv
// Combinational FP32 adder: align, add/sub magnitudes, normalise, truncate.
// Subnormals flush to zero; a zero operand passes the other through untouched.
module fpadd_unpipe
  import fp32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  logic              a_zero, b_zero, a_big, sign, sub;
  logic [31:0]       big, sml;
  logic [23:0]       m_l, m_s, m_s_al;
  logic [EXP_W-1:0]  d;
  logic [24:0]       sum;
  logic [4:0]        lz;
  logic [8:0]        e_big, e_inc, e_res;
  logic [FRAC_W-1:0] frac_n;

  always_comb begin
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_big  = (a[30:0] >= b[30:0]);
    big    = a_big ? a : b;
    sml    = a_big ? b : a;
    sign   = big[31];
    sub    = big[31] ^ sml[31];
    m_l    = {1'b1, big[22:0]};
    m_s    = {1'b1, sml[22:0]};
    d      = big[30:23] - sml[30:23];
    m_s_al = m_s >> d;
    sum    = sub ? ({1'b0, m_l} - {1'b0, m_s_al}) : ({1'b0, m_l} + {1'b0, m_s_al});
    lz     = lzc24(sum[23:0]);
    e_big  = {1'b0, big[30:23]};
    e_inc  = e_big + 9'd1;
    e_res  = e_big - {4'd0, lz};
    frac_n = sum[22:0] << lz;

    if (a_zero) begin
      out = b;
    end else if (b_zero) begin
      out = a;
    end else if (sum == 25'd0) begin
      out = FP32_ZERO;
    end else if (sum[24]) begin
      // Carry out: shift right one place, saturate to infinity on overflow.
      if (e_inc >= 9'd255) out = {sign, 8'hFF, 23'd0};
      else                 out = {sign, e_inc[7:0], sum[23:1]};
    end else if ({4'd0, lz} >= e_big) begin
      out = {sign, 31'd0};
    end else begin
      out = {sign, e_res[7:0], frac_n};
    end
  end

endmodule

// File: rtl/fp32_accum_stream.sv
// Streaming FP32 frame accumulator: one term per cycle, one registered sum per frame.
// Result appears on the accept edge of the closing term and is held until out_ready.
module fp32_accum_stream
  import fp32_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] N_LIM = CNT_W'(N_TERMS);

  state_t            state_q, state_d;
  logic [31:0]       acc_q, acc_d, sum_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_sum_q, out_sum_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              accept;

  fpadd_unpipe u_add (
    .a   (acc_q),
    .b   (in_data),
    .out (sum_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= FP32_ZERO;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= FP32_ZERO;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    accept      = in_valid & in_ready_q;
    cnt_inc     = cnt_q + 1'b1;

    case (state_q)
      ST_ACC: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (accept) begin
          acc_d = sum_nxt;
          cnt_d = cnt_inc;
          // in_last and a full count together still close just this frame.
          if (in_last || (cnt_inc == N_LIM)) begin
            out_sum_d   = sum_nxt;
            out_count_d = cnt_inc;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = FP32_ZERO;
          cnt_d       = '0;
          in_ready_d  = 1'b1;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_fp32_accum_stream.sv
// Bench for fp32_accum_stream: directed frames plus random integer-valued frames
// whose exact sums are computed with integer arithmetic and encoded as FP32.
module tb_fp32_accum_stream;

  localparam int N  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = 32'h0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_sum;
  logic [CW-1:0] out_count;

  int checks   = 0;
  int failures = 0;

  fp32_accum_stream #(.N_TERMS(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Exact FP32 encoding of an integer with |v| < 2**24.
  function automatic logic [31:0] to_fp(input int v);
    int          m, p;
    logic [31:0] r, e, f;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if ((m >> i) != 0) p = i;
    e = 32'(127 + p);
    f = 32'(m << (23 - p)) & 32'h007F_FFFF;
    r = {(v < 0), e[7:0], f[22:0]};
    return r;
  endfunction

  task automatic push(input logic [31:0] d, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
    chk("push_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic take(input string tag, input logic [31:0] es, input int ec);
    @(negedge clk);
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_count"}, {16'd0, out_count}, 32'(ec));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int q[$];
    int fsum[3];
    int s, v, len, idx, res, cyc, bubbles;
    logic take_now;

    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_sum", out_sum, 32'h0);
    chk("rst_out_count", {16'd0, out_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("deassert_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("first_cycle_in_ready", {31'd0, in_ready}, 32'd1);

    // Four terms closed by in_last.
    push(32'h42C40000, 1'b0);
    push(32'h43290000, 1'b0);
    push(32'hC2B20000, 1'b0);
    push(32'h00000000, 1'b1);
    take("t1", 32'h43320000, 4);

    // Two-term frame; result visible right after the accept edge.
    push(32'h42C60000, 1'b0);
    push(32'hC2B20000, 1'b1);
    chk("t2_latency", {31'd0, out_valid}, 32'd1);
    take("t2", 32'h41200000, 2);

    // Stalled output: result held, input ignored.
    push(32'h42C40000, 1'b0);
    push(32'h43290000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = 1'($urandom);
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_sum", out_sum, 32'h43858000);
      chk("t3_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    take("t3", 32'h43858000, 2);
    push(32'h42C60000, 1'b1);
    take("t3_next", 32'h42C60000, 1);

    // Reset mid-frame.
    push(32'h42C40000, 1'b0);
    push(32'h43290000, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_rst_sum", out_sum, 32'h0);
    chk("t4_rst_count", {16'd0, out_count}, 32'd0);
    chk("t4_rst_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(32'hC2EA0000, 1'b1);
    take("t4", 32'hC2EA0000, 1);

    // All-zero full frame, closed by the term count alone.
    for (int i = 0; i < N; i++) push(32'h0, 1'b0);
    take("t5", 32'h0, N);

    // Random integer-valued frames; a full frame may also carry in_last.
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, N);
      s = 0;
      for (int i = 0; i < len; i++) begin
        v = int'($urandom_range(0, 2000)) - 1000;
        s += v;
        push(to_fp(v), (i == len - 1) && ((len < N) || ($urandom_range(0, 1) == 1)));
      end
      take("rand", to_fp(s), len);
    end

    // Continuous stream, three full frames.
    for (int f = 0; f < 3; f++) begin
      fsum[f] = 0;
      for (int i = 0; i < N; i++) begin
        v = int'($urandom_range(0, 2000)) - 1000;
        q.push_back(v);
        fsum[f] += v;
      end
    end
    out_ready = 1'b1;
    idx = 0; res = 0; cyc = 0; bubbles = 0;
    while (res < 3 && cyc < 100) begin
      @(negedge clk);
      if (out_valid) begin
        chk("t6_sum", out_sum, to_fp(fsum[res]));
        chk("t6_count", {16'd0, out_count}, 32'(N));
        res++;
      end
      in_valid = (idx < 3 * N);
      in_last  = 1'b0;
      if (idx < 3 * N) in_data = to_fp(q[idx]);
      if (!in_ready) bubbles++;
      take_now = in_valid && in_ready;
      @(posedge clk);
      if (take_now) idx++;
      cyc++;
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t6_results", 32'(res), 32'd3);
    chk("t6_cycles", 32'(cyc), 32'd27);
    chk("t6_bubbles", 32'(bubbles), 32'd3);
    chk("t6_terms", 32'(idx), 32'(3 * N));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
